// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: APB engine state encoding,
// ctrl FIFO word layout, htrans codes and the abort data pattern.
package ahb_apb_pkg;

  // APB engine states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_WD = 3'd2,
    ST_WLOAD   = 3'd3,
    ST_WAIT_RS = 3'd4,
    ST_SETUP   = 3'd5,
    ST_ACCESS  = 3'd6
  } apb_state_t;

  // ctrl word: {hwrite, htrans, hburst, hsize, haddr}
  localparam int HWRITE_BIT = 40;
  localparam int HTRANS_MSB = 39;
  localparam int HTRANS_LSB = 38;
  localparam int HBURST_MSB = 37;
  localparam int HBURST_LSB = 35;
  localparam int HSIZE_MSB  = 34;
  localparam int HSIZE_LSB  = 32;
  localparam int HADDR_MSB  = 31;
  localparam int HADDR_LSB  = 0;

  // AHB htrans codes
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  // Read data returned when a transfer is aborted, so the AHB side never stalls
  localparam logic [31:0] APB_ABORT_DATA = 32'hDEAD_BEEF;

  // Only NSEQ/SEQ words carry a real transfer; IDLE/BUSY words are dropped
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic active;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: active = 1'b0;
      HTRANS_NSEQ, HTRANS_SEQ:  active = 1'b1;
      default:                  active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for the APB engine: counts ACCESS cycles and flags
// the cycle on which the TIMEOUT_CYCLES-th ACCESS cycle is reached.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic pclk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Count ACCESS cycles; restart on every SETUP, saturate once expired
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_fsm.sv
// APB-side master engine of the AHB-to-APB bridge. Pops ctrl words (and
// write data) from the AHB-side FIFOs, runs one APB3 SETUP/ACCESS transfer
// per active word, and pushes read data back into the APB data FIFO.
// Optional ACCESS timeout: define APB_TIMEOUT_EN.
//
// FIFO handshakes: every FIFO has registered-read semantics; a pop (ren)
// is only issued while the matching empty flag is low, and the popped word
// is consumed the following cycle. A push (wen) is only issued when the
// read-data FIFO was seen not full and no earlier push is still in flight.
module apb_fsm
  import ahb_apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_WIDTH     = 41,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  ctrl_empty,
  input  logic [CTRL_WIDTH-1:0] ctrl_rdata,
  output logic                  ctrl_ren,
  input  logic                  ahb_data_empty,
  input  logic [DATA_WIDTH-1:0] ahb_data_rdata,
  output logic                  ahb_data_ren,
  input  logic                  apb_data_full,
  output logic                  apb_data_wen,
  output logic [DATA_WIDTH-1:0] apb_data_wdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  apb_err,
  output logic [2:0]            dbg_state
);

  apb_state_t            r_state;
  apb_state_t            w_next;
  logic [31:0]           r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_wen;
  logic                  r_err;
  logic                  w_ctrl_ren;
  logic                  w_data_ren;
  logic                  w_cmd_active;
  logic                  w_cmd_write;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_unused;

  assign w_cmd_active = htrans_active(ctrl_rdata[HTRANS_MSB:HTRANS_LSB]);
  assign w_cmd_write  = ctrl_rdata[HWRITE_BIT];
  assign w_done       = (r_state == ST_ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
  logic w_expired;

  apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .pclk      (pclk),
    .reset     (reset),
    .i_clear   (r_state == ST_SETUP),
    .i_run     (r_state == ST_ACCESS),
    .o_expired (w_expired)
  );

  assign w_abort  = (r_state == ST_ACCESS) && !pready && w_expired;
  assign w_unused = ^{ctrl_rdata[HBURST_MSB:HBURST_LSB], ctrl_rdata[HSIZE_MSB:HSIZE_LSB]};
`else
  assign w_abort  = 1'b0;
  assign w_unused = ^{ctrl_rdata[HBURST_MSB:HBURST_LSB], ctrl_rdata[HSIZE_MSB:HSIZE_LSB],
                      (TIMEOUT_CYCLES != 0)};
`endif

  // State register
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and FIFO pop decode
  always_comb begin
    w_next     = r_state;
    w_ctrl_ren = 1'b0;
    w_data_ren = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!ctrl_empty) begin
          w_ctrl_ren = 1'b1;
          w_next     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!w_cmd_active) begin
          w_next = ST_IDLE;
        end else if (w_cmd_write) begin
          if (!ahb_data_empty) begin
            w_data_ren = 1'b1;
            w_next     = ST_WLOAD;
          end else begin
            w_next = ST_WAIT_WD;
          end
        end else if (!apb_data_full && !r_wen) begin
          // A push landing this cycle is not yet reflected in the full flag
          w_next = ST_SETUP;
        end else begin
          w_next = ST_WAIT_RS;
        end
      end
      ST_WAIT_WD: begin
        if (!ahb_data_empty) begin
          w_data_ren = 1'b1;
          w_next     = ST_WLOAD;
        end
      end
      ST_WLOAD: w_next = ST_SETUP;
      ST_WAIT_RS: begin
        if (!apb_data_full && !r_wen) begin
          w_next = ST_SETUP;
        end
      end
      ST_SETUP: w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (w_done) begin
          if (!ctrl_empty) begin
            w_ctrl_ren = 1'b1;
            w_next     = ST_LOAD;
          end else begin
            w_next = ST_IDLE;
          end
        end else if (w_abort) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Command latch, write data, registered read-data push and sticky error
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_wen    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      if (r_state == ST_LOAD && w_cmd_active) begin
        r_paddr  <= ctrl_rdata[HADDR_MSB:HADDR_LSB];
        r_pwrite <= w_cmd_write;
      end
      if (r_state == ST_WLOAD) begin
        r_pwdata <= ahb_data_rdata;
      end
      if (w_done && !r_pwrite) begin
        r_wen   <= 1'b1;
        r_rdata <= prdata;
      end else if (w_abort && !r_pwrite) begin
        r_wen   <= 1'b1;
        r_rdata <= DATA_WIDTH'(APB_ABORT_DATA);
      end
      if ((w_done && pslverr) || w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ctrl_ren       = w_ctrl_ren;
  assign ahb_data_ren   = w_data_ren;
  assign psel           = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable        = (r_state == ST_ACCESS);
  assign pwrite         = r_pwrite;
  assign paddr          = r_paddr;
  assign pwdata         = r_pwdata;
  assign apb_data_wen   = r_wen;
  assign apb_data_wdata = r_rdata;
  assign apb_err        = r_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_apb_fsm.sv
// Testbench for apb_fsm: FIFO and APB slave models driven once per cycle
// (inputs #1 after the rising edge, outputs sampled on the falling edge),
// a transfer-level reference model and an expected read-data queue.
module tb_apb_fsm;
  import ahb_apb_pkg::*;

  localparam int DW       = 32;
  localparam int CW       = 41;
  localparam int TO       = 8;
  localparam int RD_DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  logic          ctrl_empty, ctrl_ren;
  logic [CW-1:0] ctrl_rdata;
  logic          ahb_data_empty, ahb_data_ren;
  logic [DW-1:0] ahb_data_rdata;
  logic          apb_data_full, apb_data_wen;
  logic [DW-1:0] apb_data_wdata;
  logic          psel, penable, pwrite;
  logic [31:0]   paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr, apb_err;
  logic [2:0]    dbg_state;

  apb_fsm #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .reset(reset),
    .ctrl_empty(ctrl_empty), .ctrl_rdata(ctrl_rdata), .ctrl_ren(ctrl_ren),
    .ahb_data_empty(ahb_data_empty), .ahb_data_rdata(ahb_data_rdata), .ahb_data_ren(ahb_data_ren),
    .apb_data_full(apb_data_full), .apb_data_wen(apb_data_wen), .apb_data_wdata(apb_data_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .apb_err(apb_err),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0]   addr;
    logic          wr;
    logic [DW-1:0] data;
  } xfer_t;

  logic [CW-1:0] ctrl_q[$];
  logic [DW-1:0] wd_q[$];
  xfer_t         exp_xfer_q[$];
  logic [DW-1:0] exp_q[$];
  int            done_cyc[$];
  int            ren_cyc[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit exp_err;

  // knobs
  int wait_fixed = 0;
  int max_wait   = 3;
  int err_pct    = 0;
  int drain_pct  = 100;
  bit force_full = 0;
  bit hold_wd    = 0;
  bit rand_hold  = 0;
  bit fixed_en   = 0;
  logic [DW-1:0] fixed_rdata = '0;

  // slave/FIFO bookkeeping
  bit pend_ctrl_pop, pend_wd_pop, pend_push;
  int rd_cnt, acc_cnt, cur_wait, pen_cnt, last_pen, n_wd_pops, n_push;
  bit cur_err;
  logic [31:0] setup_addr;

  function automatic logic [DW-1:0] slave_rdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic queue_cmd(input bit wr, input logic [1:0] ht, input logic [2:0] hb,
                           input logic [31:0] addr, input logic [DW-1:0] wdata);
    xfer_t x;
    ctrl_q.push_back({wr, ht, hb, 3'b010, addr});
    // only NSEQ (2) and SEQ (3) words become APB transfers
    if (ht >= 2'd2) begin
      x.addr = addr;
      x.wr   = wr;
      x.data = wr ? wdata : (fixed_en ? fixed_rdata : slave_rdata(addr));
      exp_xfer_q.push_back(x);
      if (wr) wd_q.push_back(wdata);
    end
  endtask

  task automatic drive_inputs();
    if (pend_ctrl_pop && ctrl_q.size() > 0) ctrl_rdata = ctrl_q.pop_front();
    if (pend_wd_pop && wd_q.size() > 0) ahb_data_rdata = wd_q.pop_front();
    if (pend_push) rd_cnt++;
    if (rd_cnt > 0 && int'($urandom_range(0, 99)) < drain_pct) rd_cnt--;
    pend_ctrl_pop = 0;
    pend_wd_pop   = 0;
    pend_push     = 0;
    ctrl_empty     = (ctrl_q.size() == 0);
    ahb_data_empty = (wd_q.size() == 0) || hold_wd || (rand_hold && $urandom_range(0, 3) == 0);
    apb_data_full  = (rd_cnt >= RD_DEPTH) || force_full;
    pready  = penable && (acc_cnt >= cur_wait);
    pslverr = pready && cur_err;
    prdata  = pready ? (fixed_en ? fixed_rdata : slave_rdata(paddr)) : DW'($urandom);
  endtask

  task automatic sample_outputs();
    xfer_t x;
    cyc++;
    check("penable_without_psel", penable && !psel, 1'b0);
    if (ctrl_ren) begin
      check("ctrl_pop_nonempty", ctrl_empty, 1'b0);
      pend_ctrl_pop = 1;
      ren_cyc.push_back(cyc);
    end
    if (ahb_data_ren) begin
      check("wd_pop_nonempty", ahb_data_empty, 1'b0);
      pend_wd_pop = 1;
      n_wd_pops++;
    end
    if (psel && !penable) begin
      setup_addr = paddr;
      acc_cnt    = 0;
      pen_cnt    = 0;
      cur_wait   = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, max_wait));
      cur_err    = int'($urandom_range(0, 99)) < err_pct;
    end else if (psel && penable) begin
      check("paddr_stable", paddr, setup_addr);
      pen_cnt++;
      if (pready) begin
        if (exp_xfer_q.size() == 0) begin
          check("unexpected_xfer", 1'b1, 1'b0);
        end else begin
          x = exp_xfer_q.pop_front();
          check("paddr", paddr, x.addr);
          check("pwrite", pwrite, x.wr);
          if (x.wr) check("pwdata", pwdata, x.data);
          else exp_q.push_back(x.data);
        end
        if (cur_err) exp_err = 1;
        done_cyc.push_back(cyc);
        last_pen = pen_cnt;
        pen_cnt  = 0;
      end else begin
        acc_cnt++;
      end
    end
    if (apb_data_wen) begin
      check("push_not_full", rd_cnt < RD_DEPTH, 1'b1);
      if (exp_q.size() == 0) check("unexpected_push", 1'b1, 1'b0);
      else check("push_data", apb_data_wdata, exp_q.pop_front());
      pend_push = 1;
      n_push++;
    end
  endtask

  task automatic cycle();
    @(posedge pclk);
    #1;
    drive_inputs();
    @(negedge pclk);
    sample_outputs();
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    while (!ok && n < budget) begin
      cycle();
      n++;
      ok = (ctrl_q.size() == 0) && (exp_xfer_q.size() == 0) && (exp_q.size() == 0) &&
           (dbg_state == ST_IDLE) && !apb_data_wen && !pend_push;
    end
    if (!ok) check({"drain_", tag}, 1'b0, 1'b1);
  endtask

  task automatic clear_stats();
    done_cyc.delete();
    ren_cyc.delete();
    n_wd_pops = 0;
    n_push    = 0;
  endtask

  // ---------------- scenario ----------------
  initial begin
    reset = 1;
    ctrl_rdata = '0; ahb_data_rdata = '0; prdata = '0;
    ctrl_empty = 1; ahb_data_empty = 1; apb_data_full = 0; pready = 0; pslverr = 0;
    exp_err = 0; rd_cnt = 0; acc_cnt = 0; cur_wait = 0; cur_err = 0; pen_cnt = 0; last_pen = 0;
    pend_ctrl_pop = 0; pend_wd_pop = 0; pend_push = 0; setup_addr = '0;
    clear_stats();

    // reset values
    repeat (3) cycle();
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, '0);
    check("rst_wdata", apb_data_wdata, '0);
    check("rst_apb_err", apb_err, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge pclk); #1 reset = 0;
    @(negedge pclk);

    // single write, five-cycle latency
    clear_stats();
    wait_fixed = 0;
    queue_cmd(1, HTRANS_NSEQ, 3'b000, 32'h0000_0010, 32'hA5A5_0001);
    run_until_done("single_write", 50);
    check("sw_ctrl_pops", ren_cyc.size(), 1);
    check("sw_data_pops", n_wd_pops, 1);
    check("sw_xfers", done_cyc.size(), 1);
    if (ren_cyc.size() == 1 && done_cyc.size() == 1)
      check("sw_latency", done_cyc[0] - ren_cyc[0], 4);
    check("sw_apb_err", apb_err, 1'b0);

    // read with three wait states
    clear_stats();
    wait_fixed = 3; fixed_en = 1; fixed_rdata = 32'h1234_5678;
    queue_cmd(0, HTRANS_NSEQ, 3'b000, 32'h0000_0020, '0);
    run_until_done("read_wait", 50);
    check("rw_penable_cycles", last_pen, 4);
    check("rw_pushes", n_push, 1);
    fixed_en = 0;

    // INCR4 write burst, back-to-back
    clear_stats();
    wait_fixed = 0;
    for (int i = 0; i < 4; i++)
      queue_cmd(1, (i == 0) ? HTRANS_NSEQ : HTRANS_SEQ, 3'b011, 32'h40 + 32'(4 * i), DW'(i + 1));
    run_until_done("incr4", 80);
    check("incr4_xfers", done_cyc.size(), 4);
    for (int i = 1; i < done_cyc.size(); i++)
      check("incr4_gap", done_cyc[i] - done_cyc[i-1], 4);

    // read back-pressure: no SETUP while read FIFO full
    clear_stats();
    force_full = 1;
    queue_cmd(0, HTRANS_NSEQ, 3'b000, 32'h0000_0030, '0);
    repeat (5) begin
      cycle();
      check("full_no_psel", psel, 1'b0);
    end
    force_full = 0;
    run_until_done("full_release", 50);
    check("full_xfers", done_cyc.size(), 1);

    // write with empty data FIFO waits without APB activity
    clear_stats();
    hold_wd = 1;
    queue_cmd(1, HTRANS_NSEQ, 3'b000, 32'h0000_0034, 32'hCAFE_0034);
    repeat (5) begin
      cycle();
      check("wd_wait_no_psel", psel, 1'b0);
    end
    check("wd_wait_state", dbg_state, ST_WAIT_WD);
    hold_wd = 0;
    run_until_done("wd_release", 50);
    check("wd_xfers", done_cyc.size(), 1);

    // IDLE/BUSY words are dropped without a transfer
    clear_stats();
    queue_cmd(1, HTRANS_IDLE, 3'b000, 32'h0000_0038, 32'h0);
    queue_cmd(0, HTRANS_BUSY, 3'b000, 32'h0000_003C, 32'h0);
    run_until_done("discard", 50);
    check("discard_xfers", done_cyc.size(), 0);
    check("discard_pops", ren_cyc.size(), 2);

    // pslverr on a read: data still pushed, error sticky
    clear_stats();
    err_pct = 100;
    queue_cmd(0, HTRANS_NSEQ, 3'b000, 32'h0000_0050, '0);
    run_until_done("slverr", 50);
    check("slverr_push", n_push, 1);
    check("slverr_err", apb_err, exp_err);
    err_pct = 0;
    queue_cmd(1, HTRANS_NSEQ, 3'b000, 32'h0000_0054, 32'h0000_5454);
    run_until_done("slverr_after", 50);
    check("slverr_sticky", apb_err, 1'b1);

`ifdef APB_TIMEOUT_EN
    // ACCESS timeout on a read that never completes
    clear_stats();
    wait_fixed = 1000;
    queue_cmd(0, HTRANS_NSEQ, 3'b000, 32'h0000_0070, '0);
    void'(exp_xfer_q.pop_back());
    exp_q.push_back(32'hDEAD_BEEF);
    run_until_done("timeout", 60);
    check("to_access_cycles", pen_cnt, TO);
    check("to_err", apb_err, 1'b1);
    check("to_state", dbg_state, ST_IDLE);
    pen_cnt = 0;
    exp_err = 1;
    wait_fixed = 0;
`endif

    // reset in the middle of ACCESS
    wait_fixed = 20;
    queue_cmd(0, HTRANS_NSEQ, 3'b000, 32'h0000_0060, '0);
    begin
      int guard;
      guard = 0;
      while (!penable && guard < 50) begin
        cycle();
        guard++;
      end
      check("rst_mid_reached_access", penable, 1'b1);
    end
    #2 reset = 1;
    #1;
    check("rst_mid_psel", psel, 1'b0);
    check("rst_mid_penable", penable, 1'b0);
    check("rst_mid_err", apb_err, 1'b0);
    ctrl_q.delete(); wd_q.delete(); exp_xfer_q.delete(); exp_q.delete();
    pend_ctrl_pop = 0; pend_wd_pop = 0; pend_push = 0;
    rd_cnt = 0; acc_cnt = 0; pen_cnt = 0; exp_err = 0;
    repeat (2) cycle();
    reset = 0;
    cycle();
    check("rst_mid_idle", dbg_state, ST_IDLE);

    // randomized traffic against the transfer-level model
    clear_stats();
    wait_fixed = -1; max_wait = 3; err_pct = 10; drain_pct = 50; rand_hold = 1;
    for (int n = 0; n < 200; ) begin
      int burst;
      burst = int'($urandom_range(1, 4));
      for (int b = 0; b < burst; b++) begin
        queue_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  {$urandom_range(0, 32'hFFFF), 2'b00} & 32'h0003_FFFC, DW'($urandom));
        n++;
      end
      repeat ($urandom_range(0, 10)) cycle();
    end
    run_until_done("random", 8000);
    check("rand_apb_err", apb_err, exp_err);
    check("rand_exp_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_fsm.md
Name: apb_fsm

Overview:
- APB-side master engine of the AHB-to-APB bridge; the consumer of the FIFOs filled by the AHB-side FSM.
- Pops 41-bit control words from the ctrl FIFO and, for writes, data words from the AHB data FIFO.
- Executes one APB3 SETUP/ACCESS transfer per valid control word.
- For reads, pushes PRDATA into the APB data FIFO for the AHB side to return as HRDATA.

Parameters:
- DATA_WIDTH, 32, APB data width; equals the AHB data width.
- CTRL_WIDTH, 41, ctrl FIFO word width: {hwrite[40], htrans[39:38], hburst[37:35], hsize[34:32], haddr[31:0]}.
- TIMEOUT_CYCLES, 64, ACCESS-phase cycles without pready before abort (only with APB_TIMEOUT_EN).

Ports:
- pclk  input  1  bridge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- ctrl_empty  input  1  ctrl FIFO empty.
- ctrl_rdata  input  CTRL_WIDTH  ctrl FIFO head; valid the cycle after ctrl_ren (registered read).
- ctrl_ren  output  1  ctrl FIFO pop.
- ahb_data_empty  input  1  AHB write-data FIFO empty.
- ahb_data_rdata  input  DATA_WIDTH  write-data head; valid the cycle after ahb_data_ren.
- ahb_data_ren  output  1  write-data FIFO pop.
- apb_data_full  input  1  read-data FIFO full.
- apb_data_wen  output  1  read-data FIFO push.
- apb_data_wdata  output  DATA_WIDTH  read data pushed (PRDATA).
- psel, penable, pwrite  output  1 each  APB control.
- paddr  output  32  APB address (haddr from the ctrl word, unmodified).
- pwdata  output  DATA_WIDTH  APB write data.
- prdata  input  DATA_WIDTH  APB read data.
- pready, pslverr  input  1 each  APB completion and error.
- apb_err  output  1  sticky: slave error or timeout seen; cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All outputs 0: psel, penable, pwrite, paddr, pwdata, apb_data_wdata, apb_err. Asserting reset mid-transfer drops psel/penable immediately and discards the latched command.
- FIFO enables and psel/penable are decoded from the registered state. paddr, pwrite, pwdata and apb_data_wdata are registers.
- IDLE: if !ctrl_empty, ctrl_ren=1, go to LOAD.
- LOAD: latch ctrl_rdata into cmd.
  - htrans IDLE(00) or BUSY(01): discard; no APB transfer, no data pop; go to IDLE.
  - Write: if !ahb_data_empty, ahb_data_ren=1 and go to WLOAD; else go to WAIT_WD.
  - Read: if !apb_data_full go to SETUP; else go to WAIT_RS.
- WAIT_WD: hold until !ahb_data_empty, then ahb_data_ren=1 and go to WLOAD.
- WLOAD: pwdata<=ahb_data_rdata; go to SETUP.
- WAIT_RS: hold until !apb_data_full, then go to SETUP.
- SETUP: psel=1, penable=0; paddr/pwrite already stable; exactly one cycle; go to ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held while pready=0. On pready=1:
  - Read: apb_data_wen=1 for one cycle, apb_data_wdata=prdata.
  - pslverr=1 sets apb_err. Read data is still pushed; write data is consumed.
  - Next state: if !ctrl_empty, ctrl_ren=1 and go to LOAD (back-to-back, no IDLE cycle); else go to IDLE.
- Write latency from non-empty FIFOs with pready=1: 5 cycles from ctrl_ren to completion (ren, LOAD, WLOAD, SETUP, ACCESS).
- Ordering: strictly one outstanding APB transfer; commands executed in ctrl FIFO order; burst beats issued as independent transfers.
- Simultaneous events: ctrl_empty deasserting in the same cycle as pready is honoured (back-to-back). A read never enters SETUP while apb_data_full=1, so the push can never overflow.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter runs in ACCESS and clears on entry to SETUP. When it reaches TIMEOUT_CYCLES with pready=0, the transfer is aborted:
  - psel/penable drop and apb_err is set.
  - For a read, 32'hDEAD_BEEF is pushed so the AHB side unblocks.
  - Next state is IDLE.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Shared package ahb_apb_pkg holds:
  - state encoding;
  - ctrl word field offsets (HWRITE_BIT=40, HTRANS_MSB/LSB=39/38, HBURST, HSIZE, HADDR ranges);
  - htrans codes IDLE/BUSY/NSEQ/SEQ;
  - the 32'hDEAD_BEEF abort pattern.
- One natural sub-module: apb_timeout_cnt (counter plus expiry flag), instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Single write: ctrl {1,NSEQ,SINGLE,WORD,0x0000_0010} and data 0xA5A5_0001 queued, pready=1 -> one SETUP then one ACCESS with paddr=0x10, pwrite=1, pwdata=0xA5A5_0001; both FIFOs popped once; apb_err=0.
- Read with 3 wait states: ctrl {0,NSEQ,SINGLE,WORD,0x20}, pready low for 3 ACCESS cycles, prdata=0x1234_5678 -> penable high 4 cycles, single apb_data_wen with 0x1234_5678.
- INCR4 write burst: 4 ctrl words (NSEQ, then SEQ x3) at 0x40..0x4C with data 1..4 -> 4 transfers, back-to-back with no IDLE cycle between them, addresses and data in order.
- Back-pressure: apb_data_full=1 for 5 cycles with a read queued -> psel stays 0 until full drops; write queued with data FIFO empty -> waits in WAIT_WD, no APB activity.
- pslverr and reset: read returns pslverr=1 -> data pushed, apb_err=1 sticky. Reset asserted mid-ACCESS -> psel/penable=0 immediately and apb_err=0.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=8: read with pready stuck 0 -> abort after 8 ACCESS cycles, 0xDEAD_BEEF pushed, apb_err=1, return to IDLE.
